cpu_controller: RTL and testbench

Instruction-cycle sequencer for the 8-bit RISC CPU. Sits directly downstream of the instruction register: consumes the 3-bit opcode that `Instruction_Memory` presents on `Opcode_out` and the accumulator zero flag. Steps a fixed 8-phase fetch/execute cycle and drives every memory, program-counter, instruction-register and accumulator control strobe in the datapath. Holds a sticky halt state after a HLT instruction.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/phase_counter.sv | 33 +++
 rtl/cpu_controller.sv | 108 ++++++++++
 tb/tb_cpu_controller.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit RISC CPU: opcodes, controller phases, phase width.
package cpu_pkg;

  localparam int unsigned PHASE_W = 3;

  // Opcodes. The instruction memory and the ALU use the same encodings.
  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  // Controller phases, one per clock, 7 wraps to 0.
  localparam logic [PHASE_W-1:0] INST_ADDR  = 3'd0;
  localparam logic [PHASE_W-1:0] INST_FETCH = 3'd1;
  localparam logic [PHASE_W-1:0] INST_LOAD  = 3'd2;
  localparam logic [PHASE_W-1:0] IDLE       = 3'd3;
  localparam logic [PHASE_W-1:0] OP_ADDR    = 3'd4;
  localparam logic [PHASE_W-1:0] OP_FETCH   = 3'd5;
  localparam logic [PHASE_W-1:0] ALU_OP     = 3'd6;
  localparam logic [PHASE_W-1:0] STORE      = 3'd7;

  // Opcodes that read an operand from memory into the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Wrapping phase counter with count enable and asynchronous active-low reset.
module phase_counter #(
  parameter int unsigned Width = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  // Advance by one when enabled; natural overflow gives the wrap to 0.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Phase register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_controller.sv
// Instruction-cycle sequencer: 8-phase fetch/execute with sticky halt.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned PHASE_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         opcode,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               ld_ac,
  output logic               wr,
  output logic               data_e,
  output logic               halt,
  output logic [PHASE_W-1:0] phase
);

  logic halted_q;
  logic halted_d;
  logic halt_now;
  logic aluop;

  // HLT seen in OP_ADDR: halt this cycle and freeze the counter at OP_ADDR.
  assign halt_now = (phase == OP_ADDR) && (opcode == HLT);
  assign aluop    = is_aluop(opcode);

  phase_counter #(
    .Width (PHASE_W)
  ) u_phase_counter (
    .clock (clock),
    .reset (reset),
    .en    (~(halted_q | halt_now)),
    .count (phase)
  );

  // Halt is sticky until reset.
  always_comb begin
    halted_d = halted_q | halt_now;
  end

  // Halted flag register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Strobe decode from phase, halted flag and the live opcode/zero inputs.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == HLT);
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == JMP);
          wr     = (opcode == STO);
          data_e = (opcode == STO);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller with hand-computed strobe vectors.
module tb_cpu_controller;

  // Strobe vector bit order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
  localparam logic [8:0] P0      = 9'b100000000;
  localparam logic [8:0] P1      = 9'b110000000;
  localparam logic [8:0] P23     = 9'b111000000;
  localparam logic [8:0] P4      = 9'b000100000;
  localparam logic [8:0] P4_HLT  = 9'b000100001;
  localparam logic [8:0] NONE    = 9'b000000000;
  localparam logic [8:0] RD      = 9'b010000000;
  localparam logic [8:0] RD_LDAC = 9'b010001000;
  localparam logic [8:0] DATA_E  = 9'b000000010;
  localparam logic [8:0] WR_DE   = 9'b000000110;
  localparam logic [8:0] INC_PC  = 9'b000100000;
  localparam logic [8:0] LD_PC   = 9'b000010000;
  localparam logic [8:0] HALTED  = 9'b000000001;

  logic       clock;
  logic       reset;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  int checks;
  int failures;

  cpu_controller #(
    .PHASE_W (3)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [8:0] strobes();
    return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Runs phases 0..n-1 of one instruction starting at a negedge in phase 0.
  // Opcode is junk (HLT) in phases 0-3 and zero is inverted outside phase 6.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input int n, input logic [8:0] e4, input logic [8:0] e5,
                           input logic [8:0] e6, input logic [8:0] e7);
    logic [8:0] exp;
    for (int p = 0; p < n; p++) begin
      opcode = (p >= 4) ? op : 3'b000;
      zero   = (p == 6) ? z : ~z;
      #1;
      case (p)
        0:       exp = P0;
        1:       exp = P1;
        2, 3:    exp = P23;
        4:       exp = e4;
        5:       exp = e5;
        6:       exp = e6;
        default: exp = e7;
      endcase
      check_eq($sformatf("%s_phase%0d", tag, p), {13'd0, phase}, p[15:0]);
      check_eq($sformatf("%s_strobes%0d", tag, p), {7'd0, strobes()}, {7'd0, exp});
      @(negedge clock);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    opcode   = 3'b000;
    zero     = 1'b0;

    // Held in reset: phase 0, only sel.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq($sformatf("reset_phase%0d", i), {13'd0, phase}, 16'd0);
      check_eq($sformatf("reset_strobes%0d", i), {7'd0, strobes()}, {7'd0, P0});
    end
    reset = 1'b1;

    run_instr("lda",    3'b101, 1'b0, 8, P4, RD,   RD,     RD_LDAC);
    run_instr("sto",    3'b110, 1'b0, 8, P4, NONE, DATA_E, WR_DE);
    run_instr("skz_z1", 3'b001, 1'b1, 8, P4, NONE, INC_PC, NONE);
    run_instr("skz_z0", 3'b001, 1'b0, 8, P4, NONE, NONE,   NONE);
    run_instr("jmp",    3'b111, 1'b0, 8, P4, NONE, LD_PC,  LD_PC);
    run_instr("add",    3'b010, 1'b1, 8, P4, RD,   RD,     RD_LDAC);
    run_instr("and",    3'b011, 1'b0, 8, P4, RD,   RD,     RD_LDAC);
    run_instr("xor",    3'b100, 1'b1, 8, P4, RD,   RD,     RD_LDAC);

    // STO interrupted by reset in phase 7.
    run_instr("sto_part", 3'b110, 1'b0, 7, P4, NONE, DATA_E, WR_DE);
    opcode = 3'b110;
    #1;
    check_eq("sto7_phase", {13'd0, phase}, 16'd7);
    check_eq("sto7_strobes", {7'd0, strobes()}, {7'd0, WR_DE});
    #2 reset = 1'b0;
    #1;
    check_eq("sto_rst_phase", {13'd0, phase}, 16'd0);
    check_eq("sto_rst_strobes", {7'd0, strobes()}, {7'd0, P0});
    @(negedge clock);
    reset = 1'b1;

    // HLT: halts in phase 4 and stays there.
    run_instr("hlt", 3'b000, 1'b0, 4, P4, NONE, NONE, NONE);
    opcode = 3'b000;
    #1;
    check_eq("hlt4_phase", {13'd0, phase}, 16'd4);
    check_eq("hlt4_strobes", {7'd0, strobes()}, {7'd0, P4_HLT});
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      opcode = i[0] ? 3'b000 : 3'b010;
      zero   = i[0];
      #1;
      check_eq($sformatf("halted_phase%0d", i), {13'd0, phase}, 16'd4);
      check_eq($sformatf("halted_strobes%0d", i), {7'd0, strobes()}, {7'd0, HALTED});
      @(negedge clock);
    end
    #2 reset = 1'b0;
    #1;
    check_eq("hlt_rst_phase", {13'd0, phase}, 16'd0);
    check_eq("hlt_rst_strobes", {7'd0, strobes()}, {7'd0, P0});
    @(negedge clock);
    reset = 1'b1;

    // Normal sequencing resumes after reset.
    run_instr("lda_after", 3'b101, 1'b0, 8, P4, RD, RD, RD_LDAC);
    #1;
    check_eq("wrap_phase", {13'd0, phase}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
